// File: rtl/audio_sample_conditioner.sv
// rtl/audio_sample_conditioner.sv - DC block, ramped volume/mute gain and saturation of mono APU audio,
// emitted every clk_audio cycle as identical {right,left} channels for the HDMI packet picker.
module audio_sample_conditioner #(
   parameter int IN_WIDTH        = 16,
   parameter int AUDIO_BIT_WIDTH = 16,
   parameter int DC_SHIFT        = 10,
   parameter int DC_BYPASS       = 0,
   parameter int RAMP_STEP       = 1
) (
   input  logic                           clk_audio,
   input  logic                           reset,
   input  logic signed [IN_WIDTH-1:0]     in_sample,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [8:0]                     volume,
   input  logic                           mute,
   output logic [2*AUDIO_BIT_WIDTH-1:0]   audio_sample_word,
   output logic                           muted,
   output logic [15:0]                    underrun_count
);

   localparam int ACC_W = IN_WIDTH + DC_SHIFT + 2;
   localparam int Y_W   = IN_WIDTH + 1;
   localparam int P_W   = Y_W + 10;
   localparam int ALIGN = AUDIO_BIT_WIDTH - IN_WIDTH;
   localparam logic [8:0] STEP  = 9'(RAMP_STEP);
   localparam logic [8:0] UNITY = 9'd256;
   localparam logic signed [P_W-1:0] SAT_MAX = {{(P_W-IN_WIDTH+1){1'b0}}, {(IN_WIDTH-1){1'b1}}};
   localparam logic signed [P_W-1:0] SAT_MIN = {{(P_W-IN_WIDTH+1){1'b1}}, {(IN_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, STARVED} state_t;

   state_t                      state;
   logic                        accept;
   logic signed [IN_WIDTH-1:0]  held;
   logic signed [ACC_W-1:0]     dc_acc;
   logic signed [Y_W-1:0]       y_next;
   logic signed [Y_W-1:0]       y_reg;
   logic [8:0]                  gain;
   logic [8:0]                  gain_next;
   logic [8:0]                  target;
   logic signed [P_W-1:0]       prod;
   logic signed [P_W-1:0]       q_reg;
   logic [IN_WIDTH-1:0]         sat_val;
   logic [AUDIO_BIT_WIDTH-1:0]  chan;

   assign accept = in_valid && in_ready;

   // Stage 0: the held sample is the stage register; it repeats the last sample while starved.
   always_ff @(posedge clk_audio) begin
      if (reset) begin
         state          <= IDLE;
         in_ready       <= 1'b0;
         held           <= '0;
         underrun_count <= '0;
      end else begin
         in_ready <= 1'b1;
         if (accept)
            held <= in_sample;
         if (state != IDLE && !accept && underrun_count != 16'hFFFF)
            underrun_count <= underrun_count + 16'd1;
         case (state)
            IDLE:    if (accept) state <= RUN;
            default: state <= accept ? RUN : STARVED;
         endcase
      end
   end

   // Stage 1: leaky-integrator DC estimate subtracted from the held sample.
   always_comb begin
      if (DC_BYPASS != 0)
         y_next = Y_W'(held);
      else
         y_next = Y_W'(ACC_W'(held) - (dc_acc >>> DC_SHIFT));
   end

   always_ff @(posedge clk_audio) begin
      if (reset) begin
         dc_acc <= '0;
         y_reg  <= '0;
      end else begin
         y_reg <= y_next;
         if (DC_BYPASS == 0)
            dc_acc <= dc_acc + ACC_W'(y_next);
      end
   end

   // Gain ramps toward its target without overshoot; retargeting takes effect at once.
   always_comb begin
      target    = mute ? 9'd0 : ((volume > UNITY) ? UNITY : volume);
      gain_next = target;
      if (target > gain) begin
         if (target - gain > STEP)
            gain_next = gain + STEP;
      end else if (gain - target > STEP) begin
         gain_next = gain - STEP;
      end
   end

   assign prod = P_W'(y_reg) * P_W'($signed({1'b0, gain}));

   always_ff @(posedge clk_audio) begin
      if (reset) begin
         gain  <= '0;
         q_reg <= '0;
         muted <= 1'b0;
      end else begin
         gain  <= gain_next;
         q_reg <= prod >>> 8;
         muted <= mute && (gain_next == 9'd0);
      end
   end

   // Stage 3: clamp to the input range, then left-align into the channel width.
   always_comb begin
      if (q_reg > SAT_MAX)
         sat_val = SAT_MAX[IN_WIDTH-1:0];
      else if (q_reg < SAT_MIN)
         sat_val = SAT_MIN[IN_WIDTH-1:0];
      else
         sat_val = q_reg[IN_WIDTH-1:0];
   end

   assign chan = AUDIO_BIT_WIDTH'(sat_val) << ALIGN;

   always_ff @(posedge clk_audio) begin
      if (reset)
         audio_sample_word <= '0;
      else
         audio_sample_word <= {chan, chan};
   end

endmodule

// File: tb/tb_audio_sample_conditioner.sv
// tb/tb_audio_sample_conditioner.sv - two conditioner configurations against an arithmetic reference model
module tb_audio_sample_conditioner;

   logic clk_audio = 1'b0;
   always #5 clk_audio = ~clk_audio;

   logic               reset;
   logic               in_valid;
   logic               mute;
   logic signed [15:0] in_sample;
   logic [8:0]         volume;
   logic               in_ready_a, in_ready_b, muted_a, muted_b;
   logic [31:0]        word_a;
   logic [47:0]        word_b;
   logic [15:0]        ucnt_a, ucnt_b;

   audio_sample_conditioner #(.IN_WIDTH(16), .AUDIO_BIT_WIDTH(16), .DC_SHIFT(10),
                              .DC_BYPASS(0), .RAMP_STEP(1)) u_a (
      .clk_audio(clk_audio), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
      .in_ready(in_ready_a), .volume(volume), .mute(mute), .audio_sample_word(word_a),
      .muted(muted_a), .underrun_count(ucnt_a));

   audio_sample_conditioner #(.IN_WIDTH(16), .AUDIO_BIT_WIDTH(24), .DC_SHIFT(10),
                              .DC_BYPASS(1), .RAMP_STEP(256)) u_b (
      .clk_audio(clk_audio), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
      .in_ready(in_ready_b), .volume(volume), .mute(mute), .audio_sample_word(word_b),
      .muted(muted_b), .underrun_count(ucnt_b));

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: index 0 = u_a, index 1 = u_b.
   bit     m_valid = 1'b0;
   bit     m_ready[2], m_started[2], m_muted[2];
   longint m_held[2], m_acc[2], m_y1[2], m_y2[2], m_ch[2];
   int     m_g1[2], m_g2[2], m_cnt[2];

   function automatic longint wrap(input longint v, input int w);
      longint m = longint'(1) <<< w;
      longint r = v & (m - 1);
      if (r >= m / 2) r -= m;
      return r;
   endfunction

   function automatic longint sat16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   task automatic model_step();
      longint yk;
      int     tgt, gk, step;
      bit     acc;
      m_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_ready[i] = 0; m_started[i] = 0; m_muted[i] = 0;
            m_held[i] = 0; m_acc[i] = 0; m_y1[i] = 0; m_y2[i] = 0; m_ch[i] = 0;
            m_g1[i] = 0; m_g2[i] = 0; m_cnt[i] = 0;
         end else begin
            step = (i == 0) ? 1 : 256;
            acc  = in_valid && m_ready[i];
            // output now = saturated product of the filtered value and gain two edges back
            m_ch[i] = sat16((m_y2[i] * m_g2[i]) >>> 8);
            if (i == 1) yk = m_held[i];
            else begin
               yk = wrap(m_held[i] - (m_acc[i] >>> 10), 17);
               m_acc[i] += yk;
            end
            if (m_started[i] && !acc && m_cnt[i] < 65535) m_cnt[i]++;
            if (acc) begin
               m_started[i] = 1;
               m_held[i]    = in_sample;
            end
            tgt = mute ? 0 : ((volume > 256) ? 256 : int'(volume));
            gk  = m_g1[i];
            if ((tgt - gk <= step) && (gk - tgt <= step)) gk = tgt;
            else if (tgt > gk) gk += step;
            else gk -= step;
            m_y2[i] = m_y1[i]; m_y1[i] = yk;
            m_g2[i] = m_g1[i]; m_g1[i] = gk;
            m_muted[i] = mute && (gk == 0);
            m_ready[i] = 1;
         end
      end
   endtask

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_cond(input string name, input bit ok, input longint act, input string req);
      n_checks++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: actual %0d required %s at %0t", name, act, req, $time);
      end
   endtask

   task automatic compare_all();
      logic [15:0] la;
      logic [23:0] lb;
      la = 16'(m_ch[0]);
      lb = 24'(m_ch[1] * 256);
      check_eq("word_a", 64'(word_a), {32'd0, la, la});
      check_eq("word_b", 64'(word_b), {16'd0, lb, lb});
      check_eq("ready_a", 64'(in_ready_a), 64'(m_ready[0]));
      check_eq("ready_b", 64'(in_ready_b), 64'(m_ready[1]));
      check_eq("muted_a", 64'(muted_a), 64'(m_muted[0]));
      check_eq("muted_b", 64'(muted_b), 64'(m_muted[1]));
      check_eq("ucnt_a", 64'(ucnt_a), 64'(m_cnt[0]));
      check_eq("ucnt_b", 64'(ucnt_b), 64'(m_cnt[1]));
   endtask

   initial forever begin
      @(posedge clk_audio);
      model_step();
   end

   initial forever begin
      @(negedge clk_audio);
      #1;
      if (m_valid) compare_all();
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk_audio);
         #2;
      end
   endtask

   initial begin
      logic signed [15:0] sa;
      int n;
      reset = 1'b1; in_valid = 1'b0; in_sample = '0; volume = 9'd256; mute = 1'b0;
      tick(3);
      check_eq("reset_word_a", 64'(word_a), 64'd0);
      check_eq("reset_word_b", 64'(word_b), 64'd0);
      check_eq("reset_ready", 64'(in_ready_a), 64'd0);
      check_eq("reset_muted", 64'(muted_a), 64'd0);

      // Idle before the first sample: no underruns counted.
      reset = 1'b0;
      tick(5);
      check_eq("idle_ucnt", 64'(ucnt_a), 64'd0);
      check_eq("idle_ready", 64'(in_ready_a), 64'd1);

      // Unity path latency on u_b: accepted at the next edge, visible three edges later.
      in_valid = 1'b1; in_sample = 16'sh1234;
      tick(3);
      check_eq("lat_before", 64'(word_b), 64'd0);
      tick(1);
      check_eq("lat_at3", 64'(word_b), {16'd0, 24'h123400, 24'h123400});
      tick(300);
      check_eq("unity_b", 64'(word_b), {16'd0, 24'h123400, 24'h123400});

      // Underrun: four samples, then ten empty cycles.
      for (int k = 0; k < 3; k++) begin
         in_sample = 16'($urandom);
         tick(1);
      end
      in_sample = 16'sh0ABC;
      tick(1);
      in_valid = 1'b0;
      tick(10);
      check_eq("underrun_a", 64'(ucnt_a), 64'd10);
      check_eq("underrun_b", 64'(ucnt_b), 64'd10);
      check_eq("repeat_b", 64'(word_b), {16'd0, 24'h0ABC00, 24'h0ABC00});

      // Random traffic with volume/mute changes.
      for (int k = 0; k < 3000; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sample = 16'($urandom);
         if ($urandom_range(0, 49) == 0) begin
            volume = 9'($urandom_range(0, 511));
            mute   = ($urandom_range(0, 3) == 0);
         end
         tick(1);
      end

      // Full ramp to unity, then mute: u_a needs 256 steps down to zero.
      in_valid = 1'b1; in_sample = 16'sh4000; volume = 9'd256; mute = 1'b0;
      tick(300);
      mute = 1'b1;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!muted_a && n < 400);
      check_eq("mute_cycles", 64'(n), 64'd256);
      tick(2);
      check_eq("muted_out_a", 64'(word_a), 64'd0);

      // Reset pulse mid-stream clears the output at once.
      mute = 1'b0; volume = 9'd511; in_sample = 16'sd1000;
      reset = 1'b1;
      tick(1);
      check_eq("midreset_a", 64'(word_a), 64'd0);
      check_eq("midreset_b", 64'(word_b), 64'd0);
      check_eq("midreset_rdy", 64'(in_ready_a), 64'd0);
      reset = 1'b0;

      // DC block decay with constant 1000, then a step back to zero.
      tick(5000);
      sa = word_a[15:0];
      check_cond("dc_decay", (sa >= 0) && (sa < 10), sa, "0..9");
      check_eq("vol_clamp_b", 64'(word_b), {16'd0, 24'h03E800, 24'h03E800});
      in_sample = 16'sd0;
      tick(6);
      sa = word_a[15:0];
      check_cond("dc_step", (sa >= -1000) && (sa <= -970), sa, "-1000..-970");

      // Saturation: long negative full-scale, then positive full-scale.
      in_sample = -16'sd32768;
      tick(20000);
      in_sample = 16'sd32767;
      tick(5);
      check_eq("sat_a", 64'(word_a[15:0]), 64'h7FFF);
      check_eq("sat_b", 64'(word_b[23:0]), 64'h7FFF00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
